wrr_arbiter: RTL and testbench

WRR_ARBITER -- requirements
Module: wrr_arbiter

---
 rtl/wrr_arbiter.sv | 134 +++++++++++++
 tb/tb_wrr_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter for four requesters; grant registered, 1 cycle from request.
// An owner holds for up to weight+1 cycles and releases early when its request drops.
// Optional per-requester grant-start counters are enabled with WRR_ARBITER_STATS_EN.
module wrr_arbiter #(
    parameter int WEIGHT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [4*WEIGHT_W-1:0] weight,
    output logic [3:0]            gnt,
    output logic [1:0]            gnt_id,
    output logic                  gnt_valid
`ifdef WRR_ARBITER_STATS_EN
    ,
    output logic [31:0]           gnt_cnt
`endif
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [WEIGHT_W-1:0] cnt_q, cnt_d;
    logic [WEIGHT_W-1:0] limit_q, limit_d;
    logic [3:0]          gnt_q, gnt_d;
    logic [1:0]          gnt_id_q, gnt_id_d;
    logic                gnt_valid_q, gnt_valid_d;

    logic                rel;
    logic                start;
    logic [1:0]          base;
    logic [1:0]          owner;

    // Highest-priority set bit, searching base, base+1, ... (mod 4).
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] b);
        logic [1:0] idx;
        pick = b;
        for (int i = 3; i >= 0; i--) begin
            idx = b + 2'(i);
            if (r[idx]) pick = idx;
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        rel = 1'b0;
        if (state_q == OWN) rel = !req[gnt_id_q] || (cnt_q == limit_q);
        state_d = state_q;
        case (state_q)
            IDLE:    if (req != 4'b0000) state_d = OWN;
            OWN:     if (rel && (req == 4'b0000)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start       = 1'b0;
        base        = ptr_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        limit_d     = limit_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        if (state_q == IDLE) begin
            start = (req != 4'b0000);
        end else if (rel) begin
            ptr_d = gnt_id_q + 2'd1;
            base  = gnt_id_q + 2'd1;
            start = (req != 4'b0000);
            if (!start) begin
                gnt_d       = 4'b0000;
                gnt_id_d    = 2'd0;
                gnt_valid_d = 1'b0;
                cnt_d       = '0;
            end
        end else begin
            cnt_d = cnt_q + WEIGHT_W'(1);
        end
        owner = pick(req, base);
        // Weight is sampled only here, so changes during a hold are ignored.
        if (start) begin
            gnt_d       = 4'b0001 << owner;
            gnt_id_d    = owner;
            gnt_valid_d = 1'b1;
            cnt_d       = '0;
            limit_d     = weight[int'(owner)*WEIGHT_W +: WEIGHT_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= 2'd0;
            cnt_q       <= '0;
            limit_q     <= '0;
            gnt_q       <= 4'b0000;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            limit_q     <= limit_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

`ifdef WRR_ARBITER_STATS_EN
    logic [3:0][7:0] gnt_cnt_q, gnt_cnt_d;

    always_comb begin
        gnt_cnt_d = gnt_cnt_q;
        if (start && (gnt_cnt_q[owner] != 8'hFF)) gnt_cnt_d[owner] = gnt_cnt_q[owner] + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gnt_cnt_q <= '0;
        else        gnt_cnt_q <= gnt_cnt_d;
    end

    assign gnt_cnt = gnt_cnt_q;
`endif

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: directed vectors push expected grants, a negedge monitor pops and compares.
module tb_wrr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  weight;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        gnt_valid;
`ifdef WRR_ARBITER_STATS_EN
    logic [31:0] gnt_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    wrr_arbiter #(.WEIGHT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .weight    (weight),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
`ifdef WRR_ARBITER_STATS_EN
        ,
        .gnt_cnt   (gnt_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
        end
    endtask

    function automatic logic [1:0] id_of(input logic [3:0] e);
        id_of = 2'd0;
        for (int i = 0; i < 4; i++) if (e[i]) id_of = 2'(i);
    endfunction

    // Monitor: every cycle the bench has an expectation for, compare all grant outputs.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt", 32'(gnt), 32'(e));
                chk("gnt_id", 32'(gnt_id), 32'(id_of(e)));
                chk("gnt_valid", 32'(gnt_valid), 32'(|e));
            end
        end
    end

    // Expectation e is the output after this edge; new inputs apply from the next edge.
    task automatic cyc(input logic r_n, input logic [3:0] r, input logic [7:0] w, input logic [3:0] e);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        rst_n  = r_n;
        req    = r;
        weight = w;
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = 4'b0000;
        weight = 8'h00;

        // Reset held, then single requester with weight 3
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'b0000, 8'h00, 4'b0000);
        cyc(1'b1, 4'b0000, 8'h03, 4'b0000);
        cyc(1'b1, 4'b0001, 8'h03, 4'b0000);
        cyc(1'b1, 4'b0001, 8'h03, 4'b0001);
        cyc(1'b1, 4'b0001, 8'h03, 4'b0001);
        cyc(1'b1, 4'b0001, 8'h03, 4'b0001);
        cyc(1'b1, 4'b0000, 8'h03, 4'b0001);
        cyc(1'b1, 4'b0000, 8'h03, 4'b0000);
        cyc(1'b1, 4'b0001, 8'h03, 4'b0000);
        cyc(1'b1, 4'b0000, 8'h03, 4'b0001);
        cyc(1'b1, 4'b0000, 8'h03, 4'b0000);

        // Early release of requester 2, requester 0 follows with no bubble
        cyc(1'b1, 4'b0100, 8'h30, 4'b0000);
        cyc(1'b1, 4'b0100, 8'h30, 4'b0100);
        cyc(1'b1, 4'b0001, 8'h30, 4'b0100);
        cyc(1'b1, 4'b0001, 8'h30, 4'b0001);
        cyc(1'b1, 4'b0000, 8'h30, 4'b0001);
        cyc(1'b1, 4'b0000, 8'hC0, 4'b0000);

        // Reset while requester 3 owns: grant must vanish before the next edge
        cyc(1'b1, 4'b1000, 8'hC0, 4'b0000);
        cyc(1'b1, 4'b1000, 8'hC0, 4'b1000);
        cyc(1'b0, 4'b1001, 8'hC0, 4'b0000);
        cyc(1'b1, 4'b1001, 8'h00, 4'b0000);

        // Pointer back at 0, then zero-weight round robin
        cyc(1'b1, 4'b1111, 8'h00, 4'b0001);
        cyc(1'b1, 4'b1111, 8'h00, 4'b0010);
        cyc(1'b1, 4'b1111, 8'h00, 4'b0100);
        cyc(1'b1, 4'b1111, 8'h00, 4'b1000);
        cyc(1'b1, 4'b1111, 8'h00, 4'b0001);
        cyc(1'b1, 4'b0000, 8'h00, 4'b0010);

        // Weight1 raised from 1 to 3 mid-hold; hold stays 2 cycles
        cyc(1'b1, 4'b0010, 8'h04, 4'b0000);
        cyc(1'b1, 4'b0010, 8'h0C, 4'b0010);
        cyc(1'b1, 4'b0011, 8'h0C, 4'b0010);
        cyc(1'b1, 4'b0000, 8'h0C, 4'b0001);
        cyc(1'b1, 4'b0000, 8'h0C, 4'b0000);

`ifdef WRR_ARBITER_STATS_EN
        cyc(1'b0, 4'b0000, 8'h00, 4'b0000);
        cyc(1'b1, 4'b1000, 8'h00, 4'b0000);
        for (int i = 0; i < 300; i++) cyc(1'b1, (i == 299) ? 4'b0000 : 4'b1000, 8'h00, 4'b1000);
        cyc(1'b1, 4'b0000, 8'h00, 4'b0000);
        @(negedge clk);
        chk("gnt_cnt3", 32'(gnt_cnt[31:24]), 32'd255);
        chk("gnt_cnt_low", 32'(gnt_cnt[23:0]), 32'd0);
`endif

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
